demux3_router: RTL and testbench
================================

Name: demux3_router

Overview:
- Sequential 1-to-3 demultiplexer: the scatter counterpart of the 3-input result selectors in the processor datapath.
- Takes one WIDTH-bit producer stream with a 2-bit route code. Steers each accepted word into one of three per-destination FIFOs (a, b, c).
- Each destination drains independently under a valid/ready handshake.
- Route code 2'b11 is the invalid select, mirroring the selectors' zero default: such words are consumed and dropped, and a drop counter records them.

Parameters:
- WIDTH, 18: data width of input and all outputs.
- DEPTH, 2: entries per destination FIFO; power of two, 2 or greater.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  router accepts a word this cycle.
- in_data  in  WIDTH  word to route.
- in_sel  in  2  route code: 00 → a, 01 → b, 10 → c, 11 → drop.
- a_valid  out  1  destination a has a word.
- a_ready  in  1  destination a consumes.
- a_data  out  WIDTH  destination a word.
- b_valid, b_ready, b_data: same as a, for destination b.
- c_valid, c_ready, c_data: same as a, for destination c.
- drop_count  out  CNT_W  number of words dropped with sel 11; saturates.
- busy  out  1  at least one FIFO is non-empty.

Behaviour:
- Reset: synchronous, evaluated on the clk edge, overrides all other activity, including a transfer in flight that cycle.
  - All FIFOs empty, pointers 0.
  - a/b/c_valid = 0, a/b/c_data = 0.
  - drop_count = 0, busy = 0.
  - in_ready = 1 in the reset cycle's aftermath (all FIFOs empty).
  - Contents present before reset are discarded, not delivered.
- in_ready is combinational from in_sel and FIFO state only (no dependence on in_valid):
  - sel 00/01/10: in_ready = selected FIFO not full.
  - sel 11: in_ready = 1.
- Accept condition is in_valid && in_ready.
  - sel 00/01/10: in_data is written into the selected FIFO at that edge.
  - sel 11: drop_count increments by 1, saturating at all-ones. A held sel 11 with in_valid=1 increments every cycle.
- Output handshake:
  - x_valid = FIFO x not empty; x_data = FIFO x head, held stable while x_valid && !x_ready.
  - Pop on x_valid && x_ready.
- Latency: a word accepted at edge N is visible on x_valid/x_data after edge N, i.e. in cycle N+1. There is no combinational input-to-output path.
- Full FIFO: in_ready is based on the pre-edge state. A same-cycle pop does not allow a push into a full FIFO; the push waits one cycle. Other destinations are unaffected, but the producer stalls because the stream is in-order.
- Simultaneous push and pop on the same non-full FIFO: both happen and the count is unchanged.
  - Empty FIFO with simultaneous push: no pop occurs (valid was 0), so the count becomes 1.
- Ordering: words to the same destination leave in acceptance order. No ordering is guaranteed across destinations.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are tracked by a count of width log2(DEPTH)+1.
- busy = a_valid | b_valid | c_valid.
- x_data when x_valid=0 shows the last head-slot contents. Verification must not check it.

Decomposition:
- Shared package demux3_pkg:
  - localparams SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_DROP=2'b11.
  - Enum route_t over those codes, used by this block and the existing selector control logic.
- One sub-module, route_fifo (WIDTH, DEPTH), instantiated three times.
  - Inputs: push, push_data, pop. Outputs: full, empty, head_data.
  - Synchronous reset.
  - The top level holds only the select decode, ready mux and drop counter.

Test Plan:
1. Reset, then push 0x00011 (a), 0x00022 (b), 0x00033 (c) back-to-back, all outputs ready.
   → Each x_valid rises one cycle after its accept, data matches, in_ready stays 1, drop_count = 0.
2. b_ready=0; push 0x1, 0x2, 0x3 to b.
   → First two accepted. The third sees in_ready=0 and holds until b_ready=1 pops one, then is accepted one cycle later. b outputs 0x1, 0x2, 0x3 in order.
3. in_sel=11, in_valid=1 for 300 cycles, CNT_W=8.
   → in_ready=1 throughout, drop_count reaches 255 and stays. No x_valid is asserted.
4. FIFO a at count 1 with a_ready=1; push to a in the same cycle.
   → Count stays 1, a_data advances to the new word the next cycle, no loss or duplication.
5. Fill a and c (DEPTH=2), then assert rst for one cycle with in_valid=1, in_sel=00.
   → After the edge, all valid = 0, busy = 0, drop_count = 0, and the in-flight word is not stored.
6. Randomized sel (including 11) with random ready for 2000 cycles.
   → Per-destination scoreboard matches in order, drop_count equals the count of accepted sel-11 words (below saturation), x_data is stable under backpressure.

Source files
------------

// File: rtl/demux3_pkg.sv
// Route codes shared by the scatter router and the 3-input result selectors.
package demux3_pkg;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;

  localparam int NUM_DEST = 3;

  typedef enum logic [1:0] {
    RT_A    = SEL_A,
    RT_B    = SEL_B,
    RT_C    = SEL_C,
    RT_DROP = SEL_DROP
  } route_t;

  // One-hot destination for a route code; the drop code maps to no destination.
  function automatic logic [NUM_DEST-1:0] route_onehot(input route_t r);
    logic [NUM_DEST-1:0] oh;
    oh = '0;
    case (r)
      RT_A:    oh = 3'b001;
      RT_B:    oh = 3'b010;
      RT_C:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux3_router_fifo.sv
// Per-destination FIFO: circular buffer with count-based full/empty.
// Storage is cleared on reset so the head reads zero afterwards.
module route_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push;
  logic                        do_pop;

  // Full/empty come from the pre-edge count, so a same-cycle pop never frees a slot for a push.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux3_router.sv
// 1-to-3 scatter router: steers each accepted word into the FIFO named by
// its route code; code 11 is consumed and counted as a drop.
module demux3_router
  import demux3_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [WIDTH-1:0] c_data,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  logic [NUM_DEST-1:0]            sel_hit;
  logic [NUM_DEST-1:0]            push_v;
  logic [NUM_DEST-1:0]            pop_v;
  logic [NUM_DEST-1:0]            full_v;
  logic [NUM_DEST-1:0]            empty_v;
  logic [NUM_DEST-1:0]            ready_v;
  logic [NUM_DEST-1:0][WIDTH-1:0] head_v;
  logic                           accept;
  route_t                         route;

  assign route   = route_t'(in_sel);
  assign sel_hit = route_onehot(route);
  assign ready_v = {c_ready, b_ready, a_ready};

  // Ready depends only on the route code and FIFO occupancy, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    case (route)
      RT_A:    in_ready = !full_v[0];
      RT_B:    in_ready = !full_v[1];
      RT_C:    in_ready = !full_v[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign push_v = accept ? sel_hit : '0;
  assign pop_v  = ready_v & ~empty_v;

  for (genvar d = 0; d < NUM_DEST; d++) begin : g_dest
    route_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_v[d]),
      .push_data (in_data),
      .pop       (pop_v[d]),
      .full      (full_v[d]),
      .empty     (empty_v[d]),
      .head_data (head_v[d])
    );
  end

  assign a_valid = !empty_v[0];
  assign b_valid = !empty_v[1];
  assign c_valid = !empty_v[2];
  assign a_data  = head_v[0];
  assign b_data  = head_v[1];
  assign c_data  = head_v[2];
  assign busy    = |(~empty_v);

  // Saturating count of accepted drop-code words.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (accept && (route == RT_DROP) && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux3_router.sv
// Bench for demux3_router: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_demux3_router;

  localparam int W  = 18;
  localparam int D  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          a_valid, a_ready, b_valid, b_ready, c_valid, c_ready;
  logic [W-1:0]  a_data, b_data, c_data;
  logic [CW-1:0] drop_count;
  logic          busy;

  demux3_router #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] qc[$];
  int           mdrop;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: each destination is a bounded queue, drops are a saturating tally.
  always @(posedge clk) begin
    bit rdy, pa, pb, pc;
    if (rst) begin
      qa.delete(); qb.delete(); qc.delete();
      mdrop = 0;
    end else begin
      case (in_sel)
        2'd0:    rdy = qa.size() < D;
        2'd1:    rdy = qb.size() < D;
        2'd2:    rdy = qc.size() < D;
        default: rdy = 1'b1;
      endcase
      pa = a_ready && qa.size() > 0;
      pb = b_ready && qb.size() > 0;
      pc = c_ready && qc.size() > 0;
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (pc) void'(qc.pop_front());
      if (in_valid && rdy) begin
        case (in_sel)
          2'd0:    qa.push_back(in_data);
          2'd1:    qb.push_back(in_data);
          2'd2:    qc.push_back(in_data);
          default: if (mdrop < 255) mdrop++;
        endcase
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    bit er;
    if (chk_en) begin
      case (in_sel)
        2'd0:    er = qa.size() < D;
        2'd1:    er = qb.size() < D;
        2'd2:    er = qc.size() < D;
        default: er = 1'b1;
      endcase
      check("in_ready", 32'(in_ready), 32'(er));
      check("a_valid", 32'(a_valid), 32'(qa.size() > 0));
      check("b_valid", 32'(b_valid), 32'(qb.size() > 0));
      check("c_valid", 32'(c_valid), 32'(qc.size() > 0));
      if (qa.size() > 0) check("a_data", 32'(a_data), 32'(qa[0]));
      if (qb.size() > 0) check("b_data", 32'(b_data), 32'(qb[0]));
      if (qc.size() > 0) check("c_data", 32'(c_data), 32'(qc[0]));
      check("drop_count", 32'(drop_count), 32'(mdrop));
      check("busy", 32'(busy), 32'(qa.size() + qb.size() + qc.size() > 0));
    end
  end

  // Present a word and hold it until accepted (bounded).
  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    bit r;
    r = 1'b0;
    in_valid = 1'b1; in_sel = s; in_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #2;
      if (r) break;
    end
    check("accept_timeout", 32'(r), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_a_data", 32'(a_data), 32'd0);
    @(posedge clk); #2;

    // 1: one word to each destination back-to-back
    send(2'd0, 18'h00011);
    send(2'd1, 18'h00022);
    send(2'd2, 18'h00033);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_c_valid", 32'(c_valid), 32'd1);
    check("t1_c_data", 32'(c_data), 32'h33);
    idle(3);

    // 2: backpressure on b, third word stalls until one pop
    b_ready = 1'b0;
    send(2'd1, 18'h1);
    send(2'd1, 18'h2);
    fork
      send(2'd1, 18'h3);
      begin
        @(negedge clk);
        check("t2_stall_ready", 32'(in_ready), 32'd0);
        check("t2_b_head", 32'(b_data), 32'h1);
        repeat (2) @(posedge clk);
        #2 b_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_b_data3", 32'(b_data), 32'h3);
    idle(3);

    // 3: held drop code saturates the counter
    in_valid = 1'b1; in_sel = 2'd3;
    repeat (300) @(posedge clk);
    #2 in_valid = 1'b0;
    @(negedge clk);
    check("t3_drop_sat", 32'(drop_count), 32'd255);
    check("t3_no_valid", 32'({a_valid, b_valid, c_valid}), 32'd0);
    idle(1);

    // 4: push and pop on a count-1 FIFO in the same cycle
    a_ready = 1'b0;
    send(2'd0, 18'h44);
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 18'h55;
    @(negedge clk);
    check("t4_head_old", 32'(a_data), 32'h44);
    @(posedge clk); #2 in_valid = 1'b0;
    @(negedge clk);
    check("t4_head_new", 32'(a_data), 32'h55);
    check("t4_valid", 32'(a_valid), 32'd1);
    @(posedge clk); #2;
    @(negedge clk);
    check("t4_drained", 32'(a_valid), 32'd0);
    @(posedge clk); #2;

    // 5: reset with a and c full and a word in flight
    a_ready = 1'b0; c_ready = 1'b0;
    send(2'd0, 18'h1); send(2'd0, 18'h2);
    send(2'd2, 18'h3); send(2'd2, 18'h4);
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 18'h77;
    @(posedge clk); #2 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_a_valid", 32'(a_valid), 32'd0);
    check("t5_c_valid", 32'(c_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_drop", 32'(drop_count), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_a_data", 32'(a_data), 32'd0);
    @(posedge clk); #2;
    a_ready = 1'b1; c_ready = 1'b1;

    // 6: random traffic with random backpressure
    repeat (2000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sel   = 2'($urandom_range(0, 3));
      in_data  = W'($urandom);
      a_ready  = 1'($urandom_range(0, 1));
      b_ready  = 1'($urandom_range(0, 1));
      c_ready  = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    idle(6);
    @(negedge clk);
    check("t6_drained", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
